videoram_writer: RTL and testbench
==================================

# videoram_writer

Write-side companion to the text-mode video RAM. Accepts one character byte at a time from the JML-8 bus-side interface over a valid/ready handshake and keeps a text cursor. Turns each byte into single-cycle write strobes (row, column, data) into the character RAM. Handles control codes and scrolling; scrolling is done by rotating a row-base offset that the display read path adds to its tile row, not by moving RAM contents.

## Interface
Parameters:
- HTILES, 80, character columns (640 px / 8)
- VTILES, 60, character rows (480 px / 8)
- BLANK, 8'h20, code written when clearing

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous and active-low
- in_data  in  8  character or control code
- in_valid  in  1  in_data is presented
- in_ready  out  1  block can accept a byte this cycle
- wr_en  out  1  RAM write strobe, one cycle per write
- wr_row  out  $clog2(VTILES)  physical RAM row
- wr_col  out  $clog2(HTILES)  RAM column
- wr_data  out  8  byte to write
- row_base  out  $clog2(VTILES)  physical row shown as screen row 0
- cur_row  out  $clog2(VTILES)  cursor screen row
- cur_col  out  $clog2(HTILES)  cursor column

## Operation
- States:
  - IDLE
  - PUT: one write
  - CLRLINE: HTILES writes
  - CLRALL: HTILES*VTILES writes
- in_ready = (state == IDLE). A byte is accepted on a rising edge where in_valid && in_ready.
- Physical row = (row_base + screen row) mod VTILES.
  - The sum is at most 2*VTILES-2.
  - Reduce it with a single conditional subtract.
- Decoding of an accepted byte:
  - 0x0D CR: cur_col <= 0. Stays IDLE with no write.
  - 0x08 BS: if cur_col > 0, cur_col <= cur_col-1. Stays IDLE with no write; at column 0 nothing changes.
  - 0x0A LF: if cur_row < VTILES-1, cur_row++ and stay IDLE. Otherwise go to CLRLINE.
  - 0x0C FF: go to CLRALL.
  - Any other code: go to PUT. wr_data = byte, wr_row/wr_col = cursor's physical address.
- PUT end:
  - If cur_col < HTILES-1, cur_col++.
  - Otherwise cur_col <= 0 and apply the LF rule: row++ and go to IDLE, or at the bottom row go to CLRLINE.
- CLRLINE:
  - wr_row = current row_base, which is the old top row and becomes the new bottom row.
  - wr_col = 0..HTILES-1, wr_data = BLANK.
  - After the last column: row_base <= (row_base+1) mod VTILES, cur_row stays VTILES-1, go to IDLE.
- CLRALL:
  - Writes BLANK to physical rows 0..VTILES-1, row-major, column fastest.
  - Then row_base <= 0, cursor <= (0,0), go to IDLE.
- Only IDLE accepts bytes, so at most one sequence runs at a time.
- Reset (asynchronous, any state, including mid-CLRLINE or mid-CLRALL):
  - state IDLE, wr_en 0, wr_row/wr_col/wr_data 0.
  - row_base 0, cursor (0,0).
  - A partially cleared region is left as written.

## Timing
- All outputs are registered except in_ready, which is decoded combinationally from state.
- A printable byte accepted at edge k gives wr_en=1 during cycle k+1, with the address and data stable for that cycle. The block is back in IDLE, with in_ready=1, in cycle k+2.
  - Sustained throughput: one printable byte per 2 cycles.
- CR, BS, and LF without scroll take effect at edge k; in_ready stays 1.
- Scroll: wr_en high for HTILES consecutive cycles, starting in the cycle after entry to CLRLINE.
  - row_base updates on the edge ending the last write.
  - in_ready returns to 1 in the next cycle.
- CLRALL: HTILES*VTILES consecutive write cycles. Cursor and row_base update on the edge ending the last write.
- Outside the PUT, CLRLINE and CLRALL write cycles, wr_en is 0.
- wr_row/wr_col/wr_data may hold stale values whenever wr_en is 0.

## Structure
- HTILES, VTILES, the derived widths, and the control-code constants (CR, LF, BS, FF) go in the shared vgaspecs.vh, alongside the display timing constants. The read path uses the same widths.
- Sub-module `row_wrap`: combinational (a + b) mod VTILES with a single conditional subtract. It is used for the physical-row computation and for the row_base increment.
- The display read path must add row_base to its tile row through `row_wrap`. That is a required integration change.

## Test plan
- Reset, then send 'A' (0x41): in_ready is 1 in the accept cycle; next cycle wr_en=1, row 0, col 0, data 0x41; afterwards cur_col=1.
- Send 80 × 0x41: the 80th write is at col 79; afterwards cursor = (1,0), row_base 0, no CLRLINE.
- From cursor (3,10), send BS, BS, CR, then BS at col 0: cursor goes 9 → 8 → 0 → 0, and wr_en is never asserted.
- Send 59 LFs, then one more: the last LF gives 80 cycles of wr_en with row 0, cols 0..79, data 0x20. Then row_base=1, cur_row=59, and in_ready is 0 throughout the scroll. Then send 'B': the write lands on physical row 0.
- After 60 scrolls (row_base wraps 59 → 0), send FF: 4800 write cycles, last write at (59,79); then row_base 0 and cursor (0,0).
- Assert rst_n low mid-CLRALL, with in_valid held high: the block is asynchronously in IDLE with wr_en 0 and cursor (0,0). The first byte presented after release is accepted on the first clock edge.

Source files
------------

// File: rtl/videoram_writer_pkg.sv
// Shared types and control-code constants for the text-mode video RAM writer.
// Geometry defaults match the 640x480 display with 8x8 character tiles.
package videoram_writer_pkg;

    localparam int DEF_HTILES = 80;
    localparam int DEF_VTILES = 60;

    localparam logic [7:0] CHR_BS = 8'h08;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_FF = 8'h0C;
    localparam logic [7:0] CHR_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PUT     = 2'd1,
        ST_CLRLINE = 2'd2,
        ST_CLRALL  = 2'd3
    } state_t;

endpackage

// File: rtl/videoram_writer_row_wrap.sv
// Combinational (a + b) mod VTILES for operands already below VTILES.
// Both operands are < VTILES, so a single conditional subtract is enough.
module row_wrap #(
    parameter  int VTILES = 60,
    localparam int RW     = $clog2(VTILES)
) (
    input  logic [RW-1:0] i_a,
    input  logic [RW-1:0] i_b,
    output logic [RW-1:0] o_y
);

    logic [RW:0] w_sum;
    logic [RW:0] w_red;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_red = w_sum - (RW+1)'(VTILES);
    assign o_y   = (w_sum >= (RW+1)'(VTILES)) ? w_red[RW-1:0] : w_sum[RW-1:0];

endmodule

// File: rtl/videoram_writer.sv
// Byte-stream to character-RAM write strobes with a text cursor.
// Scrolling rotates row_base instead of moving RAM contents.
module videoram_writer
    import videoram_writer_pkg::*;
#(
    parameter  int         HTILES = DEF_HTILES,
    parameter  int         VTILES = DEF_VTILES,
    parameter  logic [7:0] BLANK  = 8'h20,
    localparam int         CW     = $clog2(HTILES),
    localparam int         RW     = $clog2(VTILES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [RW-1:0] wr_row,
    output logic [CW-1:0] wr_col,
    output logic [7:0]    wr_data,
    output logic [RW-1:0] row_base,
    output logic [RW-1:0] cur_row,
    output logic [CW-1:0] cur_col
);

    localparam logic [CW-1:0] COL_LAST = CW'(HTILES - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(VTILES - 1);

    state_t        r_state,    w_nxt_state;
    logic          r_wr_en,    w_nxt_wr_en;
    logic [RW-1:0] r_wr_row,   w_nxt_wr_row;
    logic [CW-1:0] r_wr_col,   w_nxt_wr_col;
    logic [7:0]    r_wr_data,  w_nxt_wr_data;
    logic [RW-1:0] r_row_base, w_nxt_row_base;
    logic [RW-1:0] r_cur_row,  w_nxt_cur_row;
    logic [CW-1:0] r_cur_col,  w_nxt_cur_col;

    logic [RW-1:0] w_cur_phys;
    logic [RW-1:0] w_base_inc;
    logic          w_accept;

    row_wrap #(.VTILES(VTILES)) u_phys_row (
        .i_a (r_row_base),
        .i_b (r_cur_row),
        .o_y (w_cur_phys)
    );

    row_wrap #(.VTILES(VTILES)) u_base_inc (
        .i_a (r_row_base),
        .i_b (RW'(1)),
        .o_y (w_base_inc)
    );

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wr_en    <= 1'b0;
            r_wr_row   <= '0;
            r_wr_col   <= '0;
            r_wr_data  <= '0;
            r_row_base <= '0;
            r_cur_row  <= '0;
            r_cur_col  <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_wr_en    <= w_nxt_wr_en;
            r_wr_row   <= w_nxt_wr_row;
            r_wr_col   <= w_nxt_wr_col;
            r_wr_data  <= w_nxt_wr_data;
            r_row_base <= w_nxt_row_base;
            r_cur_row  <= w_nxt_cur_row;
            r_cur_col  <= w_nxt_cur_col;
        end
    end

    // The first write of every sequence is registered on the entry edge, so
    // wr_en is high exactly for the cycles spent in PUT/CLRLINE/CLRALL.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_wr_en    = 1'b0;
        w_nxt_wr_row   = r_wr_row;
        w_nxt_wr_col   = r_wr_col;
        w_nxt_wr_data  = r_wr_data;
        w_nxt_row_base = r_row_base;
        w_nxt_cur_row  = r_cur_row;
        w_nxt_cur_col  = r_cur_col;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    unique case (in_data)
                        CHR_CR: w_nxt_cur_col = '0;
                        CHR_BS: begin
                            if (r_cur_col != '0)
                                w_nxt_cur_col = r_cur_col - CW'(1);
                        end
                        CHR_LF: begin
                            if (r_cur_row < ROW_LAST) begin
                                w_nxt_cur_row = r_cur_row + RW'(1);
                            end else begin
                                w_nxt_state   = ST_CLRLINE;
                                w_nxt_wr_en   = 1'b1;
                                w_nxt_wr_row  = r_row_base;
                                w_nxt_wr_col  = '0;
                                w_nxt_wr_data = BLANK;
                            end
                        end
                        CHR_FF: begin
                            w_nxt_state   = ST_CLRALL;
                            w_nxt_wr_en   = 1'b1;
                            w_nxt_wr_row  = '0;
                            w_nxt_wr_col  = '0;
                            w_nxt_wr_data = BLANK;
                        end
                        default: begin
                            w_nxt_state   = ST_PUT;
                            w_nxt_wr_en   = 1'b1;
                            w_nxt_wr_row  = w_cur_phys;
                            w_nxt_wr_col  = r_cur_col;
                            w_nxt_wr_data = in_data;
                        end
                    endcase
                end
            end

            ST_PUT: begin
                w_nxt_state = ST_IDLE;
                if (r_cur_col < COL_LAST) begin
                    w_nxt_cur_col = r_cur_col + CW'(1);
                end else begin
                    w_nxt_cur_col = '0;
                    if (r_cur_row < ROW_LAST) begin
                        w_nxt_cur_row = r_cur_row + RW'(1);
                    end else begin
                        // Old top row is recycled as the new bottom row.
                        w_nxt_state   = ST_CLRLINE;
                        w_nxt_wr_en   = 1'b1;
                        w_nxt_wr_row  = r_row_base;
                        w_nxt_wr_col  = '0;
                        w_nxt_wr_data = BLANK;
                    end
                end
            end

            ST_CLRLINE: begin
                if (r_wr_col == COL_LAST) begin
                    w_nxt_state    = ST_IDLE;
                    w_nxt_row_base = w_base_inc;
                end else begin
                    w_nxt_wr_en  = 1'b1;
                    w_nxt_wr_col = r_wr_col + CW'(1);
                end
            end

            ST_CLRALL: begin
                if (r_wr_col == COL_LAST) begin
                    if (r_wr_row == ROW_LAST) begin
                        w_nxt_state    = ST_IDLE;
                        w_nxt_row_base = '0;
                        w_nxt_cur_row  = '0;
                        w_nxt_cur_col  = '0;
                    end else begin
                        w_nxt_wr_en  = 1'b1;
                        w_nxt_wr_row = r_wr_row + RW'(1);
                        w_nxt_wr_col = '0;
                    end
                end else begin
                    w_nxt_wr_en  = 1'b1;
                    w_nxt_wr_col = r_wr_col + CW'(1);
                end
            end

            default: w_nxt_state = ST_IDLE;
        endcase
    end

    assign wr_en    = r_wr_en;
    assign wr_row   = r_wr_row;
    assign wr_col   = r_wr_col;
    assign wr_data  = r_wr_data;
    assign row_base = r_row_base;
    assign cur_row  = r_cur_row;
    assign cur_col  = r_cur_col;

endmodule

// File: tb/tb_videoram_writer.sv
// Randomized bench for videoram_writer against a screen-level reference model
// that predicts each byte's write list, cursor and row_base.
module tb_videoram_writer;

    localparam int HT = 80;
    localparam int VT = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       wr_en;
    logic [5:0] wr_row;
    logic [6:0] wr_col;
    logic [7:0] wr_data;
    logic [5:0] row_base;
    logic [5:0] cur_row;
    logic [6:0] cur_col;

    int total = 0;
    int bad   = 0;

    int mr = 0, mc = 0, mb = 0;
    logic [31:0] expq[$];

    videoram_writer #(.HTILES(HT), .VTILES(VT), .BLANK(8'h20)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_data  (wr_data),
        .row_base (row_base),
        .cur_row  (cur_row),
        .cur_col  (cur_col)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wpack(input int r, input int c, input int d);
        return 32'((r << 16) | (c << 8) | d);
    endfunction

    function automatic logic [31:0] obs_pack();
        return wpack(int'(wr_row), int'(wr_col), int'(wr_data));
    endfunction

    function automatic void m_newline();
        if (mr < VT - 1) mr++;
        else begin
            for (int c = 0; c < HT; c++) expq.push_back(wpack(mb, c, 8'h20));
            mb = (mb + 1) % VT;
        end
    endfunction

    function automatic void m_apply(input logic [7:0] b);
        case (b)
            8'h0D: mc = 0;
            8'h08: if (mc > 0) mc--;
            8'h0A: m_newline();
            8'h0C: begin
                for (int r = 0; r < VT; r++)
                    for (int c = 0; c < HT; c++) expq.push_back(wpack(r, c, 8'h20));
                mb = 0; mr = 0; mc = 0;
            end
            default: begin
                expq.push_back(wpack((mb + mr) % VT, mc, b));
                mc++;
                if (mc == HT) begin
                    mc = 0;
                    m_newline();
                end
            end
        endcase
    endfunction

    task automatic send(input logic [7:0] b);
        int nexp, nbusy, cyc;
        logic [31:0] obs[$];
        cyc = 0;
        while (!in_ready && cyc < 8000) begin
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b1;
        in_data  = b;
        chk("rdy_acc", 32'(in_ready), 32'd1);
        m_apply(b);
        nexp = expq.size();
        @(negedge clk);
        in_valid = 1'b0;
        nbusy = 0;
        while (!in_ready && nbusy < 8000) begin
            if (wr_en) obs.push_back(obs_pack());
            nbusy++;
            // Garbage offered while busy must never be taken.
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("busy_cyc", 32'(nbusy), 32'(nexp));
        chk("n_writes", 32'(obs.size()), 32'(nexp));
        for (int i = 0; i < obs.size() && i < nexp; i++) chk("wr", obs[i], expq[i]);
        expq.delete();
        chk("idle_wr_en", 32'(wr_en), 32'd0);
        chk("cur_row", 32'(cur_row), 32'(mr));
        chk("cur_col", 32'(cur_col), 32'(mc));
        chk("row_base", 32'(row_base), 32'(mb));
    endtask

    initial begin
        int pick;
        logic [7:0] b;

        #2;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", obs_pack(), 32'd0);
        chk("rst_cursor", {20'd0, 6'(cur_row), 6'(cur_col[5:0])}, 32'd0);
        chk("rst_base", 32'(row_base), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 'A', then fill the line to the wrap point.
        send(8'h41);
        for (int i = 0; i < 79; i++) send(8'h41);

        // Cursor to (3,10), then BS, BS, CR, BS.
        send(8'h0A); send(8'h0A); send(8'h0D);
        for (int i = 0; i < 10; i++) send(8'h78);
        send(8'h08); send(8'h08); send(8'h0D); send(8'h08);

        // Walk to the bottom and scroll once, then print.
        while (mr < VT - 1) send(8'h0A);
        send(8'h0A);
        send(8'h42);

        // Keep scrolling until row_base wraps back to 0, then clear screen.
        send(8'h0A);
        while (mb != 0) send(8'h0A);
        send(8'h0C);

        // Mixed random traffic with idle gaps.
        for (int n = 0; n < 400; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            pick = $urandom_range(0, 99);
            if (pick < 70)      b = 8'($urandom_range(32, 126));
            else if (pick < 80) b = 8'h0A;
            else if (pick < 88) b = 8'h0D;
            else if (pick < 96) b = 8'h08;
            else                b = 8'($urandom_range(0, 255));
            send(b);
        end

        // Reset in the middle of a full clear with a byte already offered.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h0C;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (100) @(negedge clk);
        chk("clrall_busy", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h43;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_wr_en", 32'(wr_en), 32'd0);
        chk("arst_wr_addr", obs_pack(), 32'd0);
        chk("arst_cur_row", 32'(cur_row), 32'd0);
        chk("arst_cur_col", 32'(cur_col), 32'd0);
        chk("arst_base", 32'(row_base), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_wr_en", 32'(wr_en), 32'd1);
        chk("post_rst_wr", obs_pack(), wpack(0, 0, 8'h43));
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_col", 32'(cur_col), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
